clockworks_gen: RTL and testbench
=================================

Name: clockworks_gen

Overview:
- Clock/reset conditioning block at the top of the SoC.
- Divides the board clock by 2^(SLOW+1) to produce a slow core clock, slow_clk.
- Provides a matching clock-enable tick, slow_tick, for logic that stays on clk.
- Generates a clean, stretched, active-low core reset, slow_resetn, that is released only after a fixed number of slow periods and only at a slow-clock falling point.
- Sits between board inputs and the CPU/SOC core.

Parameters:
- SLOW, 15: divider exponent. slow_clk period is 2^(SLOW+1) clk cycles. Legal range 0..30.
- RESET_HOLD, 4: number of complete slow_clk periods slow_resetn is held low after resetn deasserts. Legal range 1..255.

Ports:
- clk  input  1  board clock; all state is on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- slow_clk  output  1  divided clock, 50% duty, equal to counter bit SLOW.
- slow_tick  output  1  high for exactly one clk cycle per slow period, in the cycle before slow_clk falls.
- slow_resetn  output  1  registered, active-low, stretched reset for the slow domain.

Behaviour:
- Reset value of the divider counter: cnt[SLOW:0] is 0 when resetn=0 is sampled.
- Reset values of the other state: hold counter hcnt (8 bits) is 0, and slow_resetn is 0. All are registered.
- resetn is sampled only on the clk rising edge. Asynchronous assertion has no effect until that edge.
- Divider: each clk edge with resetn=1 increments cnt modulo 2^(SLOW+1).
  - slow_clk = cnt[SLOW], so it is 0 right after reset.
  - slow_clk rises when cnt reaches 2^SLOW and falls when cnt wraps to 0.
- slow_tick: combinational decode, cnt == all-ones. It is 0 while resetn=0, because cnt=0.
- Wrap event: the edge where cnt goes from all-ones to 0.
- Reset stretch: while slow_resetn=0 and resetn=1, each wrap event increments hcnt.
  - On the wrap event that brings hcnt to RESET_HOLD, slow_resetn is set to 1 at that same edge.
  - hcnt then saturates and stops.
  - Timing: with the first resetn=1 edge as edge 1, slow_resetn rises at edge RESET_HOLD*2^(SLOW+1).
- slow_resetn changes only at wrap events (slow_clk falling). Downstream slow-clocked flops therefore never see a release near their active edge.
- Reset mid-operation: resetn=0 at any edge forces cnt=0, hcnt=0 and slow_resetn=0 at that edge. The full stretch restarts after release.
- After release, slow_resetn stays 1 indefinitely until resetn is next sampled low.
- No glitches: every output is either a flop output (slow_clk, slow_resetn) or a decode of flops (slow_tick).

Decomposition:
- Shared package: holds the SLOW default and the RESET_HOLD default so the SoC and benches agree on the divider ratio.
- Sub-module reset_stretcher: contains hcnt and slow_resetn, with inputs clk, resetn and wrap, and output slow_resetn.
- The top level contains the divider counter and the tick/clock decode.

Test Plan:
- Divider (SLOW=2, RESET_HOLD=4): hold resetn=0 for 3 edges, then 1.
  - Require cnt=0, slow_clk=0 and slow_resetn=0 during reset.
  - Require slow_clk to have period 8 clk cycles with 4 high / 4 low, and its first rise after edge 4.
- Tick (same configuration): require slow_tick=1 only while cnt=7, once per 8 cycles, and never during reset.
- Release timing (same configuration): require slow_resetn=0 through edge 31, 1 from edge 32 onward, and the transition to coincide with slow_clk falling.
- Reset mid-stretch: deassert resetn, then reassert it at edge 20 for 1 cycle.
  - Require slow_resetn=0, cnt=0 and hcnt=0 at that edge.
  - Require release again exactly 32 edges after the new release edge.
- Reset after release: at steady state, pulse resetn=0 for 1 edge. Require slow_resetn to fall at that edge, slow_clk=0, and the full stretch to repeat.
- Wide divider (SLOW=0, RESET_HOLD=1): require slow_clk to toggle every cycle, slow_tick to be 1 on alternate cycles, and slow_resetn to rise at edge 2.

Source files
------------

// File: rtl/clockworks_gen_pkg.sv
// Shared defaults for the board clock divider and core reset stretcher.
// SoC top and benches import these so the slow-clock ratio stays in one place.
package clockworks_gen_pkg;

  localparam int SLOW_DEF       = 15;
  localparam int RESET_HOLD_DEF = 4;
  localparam int HCNT_W         = 8;

endpackage

// File: rtl/clockworks_gen_reset_stretcher.sv
// Holds the slow-domain reset low for RESET_HOLD slow periods.
// Release happens only on a wrap, i.e. at a slow_clk falling point.
module clockworks_gen_reset_stretcher
  import clockworks_gen_pkg::*;
#(
  parameter int RESET_HOLD = RESET_HOLD_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic wrap,
  output logic slow_resetn
);

  localparam logic [HCNT_W-1:0] HOLD = HCNT_W'(RESET_HOLD);

  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] hcnt_next;

  // next hold count, only committed on a wrap while still in reset
  always_comb begin
    hcnt_next = hcnt + HCNT_W'(1);
  end

  // count wraps; release on the wrap that reaches HOLD, then freeze
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hcnt        <= '0;
      slow_resetn <= 1'b0;
    end else if (wrap && !slow_resetn) begin
      hcnt        <= hcnt_next;
      slow_resetn <= (hcnt_next == HOLD);
    end
  end

endmodule

// File: rtl/clockworks_gen.sv
// Board clock divider producing slow_clk, a matching tick,
// and a stretched, fall-aligned active-low core reset.
module clockworks_gen
  import clockworks_gen_pkg::*;
#(
  parameter int SLOW       = SLOW_DEF,
  parameter int RESET_HOLD = RESET_HOLD_DEF
) (
  input  logic clk,
  input  logic resetn,
  output logic slow_clk,
  output logic slow_tick,
  output logic slow_resetn
);

  localparam logic [SLOW:0] ONE = (SLOW+1)'(1);

  logic [SLOW:0] cnt;

  // free-running divider, cleared by the synchronous board reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

  // top bit is the 50% clock; all-ones marks the cycle before it falls
  assign slow_clk  = cnt[SLOW];
  assign slow_tick = &cnt;

  clockworks_gen_reset_stretcher #(
    .RESET_HOLD (RESET_HOLD)
  ) u_stretch (
    .clk         (clk),
    .resetn      (resetn),
    .wrap        (slow_tick),
    .slow_resetn (slow_resetn)
  );

endmodule

// File: tb/tb_clockworks_gen.sv
// Bench for clockworks_gen: two configurations against a model that
// counts clean edges since reset and derives every output from that.
module tb_clockworks_gen;

  logic clk;
  logic rst_a, rst_b;
  logic sclk_a, tick_a, srn_a;
  logic sclk_b, tick_b, srn_b;

  int checks = 0;
  int errors = 0;
  int n_a = 0;
  int n_b = 0;

  localparam int PA = 8;
  localparam int HA = 4;
  localparam int PB = 2;
  localparam int HB = 1;

  clockworks_gen #(.SLOW(2), .RESET_HOLD(4)) dut_a (
    .clk         (clk),
    .resetn      (rst_a),
    .slow_clk    (sclk_a),
    .slow_tick   (tick_a),
    .slow_resetn (srn_a)
  );

  clockworks_gen #(.SLOW(0), .RESET_HOLD(1)) dut_b (
    .clk         (clk),
    .resetn      (rst_b),
    .slow_clk    (sclk_b),
    .slow_tick   (tick_b),
    .slow_resetn (srn_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic m_clk(int n, int p);
    return logic'((n % p) >= p / 2);
  endfunction

  function automatic logic m_tick(int n, int p);
    return logic'((n % p) == p - 1);
  endfunction

  function automatic logic m_rn(int n, int p, int h);
    return logic'(n >= h * p);
  endfunction

  task automatic step(input logic ra, input logic rb);
    rst_a = ra;
    rst_b = rb;
    @(posedge clk);
    n_a = ra ? n_a + 1 : 0;
    n_b = rb ? n_b + 1 : 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if (dut_a.cnt !== 3'd0 || sclk_a !== 1'b0 ||
          srn_a !== 1'b0 || tick_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_a: cnt=%0d clk=%b tick=%b rn=%b want 0 0 0 0",
                 dut_a.cnt, sclk_a, tick_a, srn_a);
      end
      checks++;
      if (sclk_b !== 1'b0 || srn_b !== 1'b0 || tick_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_b: clk=%b tick=%b rn=%b want 0 0 0",
                 sclk_b, tick_b, srn_b);
      end
    end
  endtask

  task automatic test_divider();
    int rise_at;
    int highs;
    rise_at = -1;
    highs = 0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0);
      if (sclk_a === 1'b1 && rise_at < 0) rise_at = n_a;
      if (n_a > 8 && sclk_a === 1'b1) highs++;
      checks++;
      if (sclk_a !== m_clk(n_a, PA)) begin
        errors++;
        $display("FAIL divider edge %0d: slow_clk=%b want %b",
                 n_a, sclk_a, m_clk(n_a, PA));
      end
    end
    checks++;
    if (rise_at != 4) begin
      errors++;
      $display("FAIL first_rise: edge %0d want 4", rise_at);
    end
    checks++;
    if (highs != 8) begin
      errors++;
      $display("FAIL duty: %0d high cycles in 16 want 8", highs);
    end
  endtask

  task automatic test_tick();
    int ticks;
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0);
      if (tick_a === 1'b1) ticks++;
      checks++;
      if (tick_a !== m_tick(n_a, PA) ||
          tick_a !== logic'(dut_a.cnt == 3'd7)) begin
        errors++;
        $display("FAIL tick edge %0d: tick=%b cnt=%0d want %b",
                 n_a, tick_a, dut_a.cnt, m_tick(n_a, PA));
      end
    end
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL tick_count: %0d in 16 cycles want 2", ticks);
    end
  endtask

  task automatic test_release();
    logic prev_clk;
    int rel_at;
    step(1'b0, 1'b0);
    prev_clk = sclk_a;
    rel_at = -1;
    for (int i = 0; i < 48; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (srn_a !== m_rn(n_a, PA, HA)) begin
        errors++;
        $display("FAIL release edge %0d: slow_resetn=%b want %b",
                 n_a, srn_a, m_rn(n_a, PA, HA));
      end
      if (srn_a === 1'b1 && rel_at < 0) begin
        rel_at = n_a;
        checks++;
        if (!(prev_clk === 1'b1 && sclk_a === 1'b0)) begin
          errors++;
          $display("FAIL release_align: slow_clk %b->%b want 1->0",
                   prev_clk, sclk_a);
        end
      end
      prev_clk = sclk_a;
    end
    checks++;
    if (rel_at != 32) begin
      errors++;
      $display("FAIL release_edge: %0d want 32", rel_at);
    end
  endtask

  task automatic test_mid_stretch();
    int rel_at;
    step(1'b0, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    checks++;
    if (srn_a !== 1'b0 || dut_a.cnt !== 3'd0 ||
        dut_a.u_stretch.hcnt !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: rn=%b cnt=%0d hcnt=%0d want 0 0 0",
               srn_a, dut_a.cnt, dut_a.u_stretch.hcnt);
    end
    rel_at = -1;
    for (int i = 1; i <= 100 && rel_at < 0; i++) begin
      step(1'b1, 1'b0);
      if (srn_a === 1'b1) rel_at = i;
    end
    checks++;
    if (rel_at != 32) begin
      errors++;
      $display("FAIL mid_rerelease: edge %0d want 32", rel_at);
    end
  endtask

  task automatic test_after_release();
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0);
    checks++;
    if (srn_a !== 1'b1) begin
      errors++;
      $display("FAIL steady: slow_resetn=%b want 1", srn_a);
    end
    step(1'b0, 1'b0);
    checks++;
    if (srn_a !== 1'b0 || sclk_a !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: rn=%b clk=%b want 0 0", srn_a, sclk_a);
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0);
      checks++;
      if (srn_a !== m_rn(n_a, PA, HA) || sclk_a !== m_clk(n_a, PA)) begin
        errors++;
        $display("FAIL restretch edge %0d: rn=%b clk=%b want %b %b",
                 n_a, srn_a, sclk_a, m_rn(n_a, PA, HA), m_clk(n_a, PA));
      end
    end
  endtask

  task automatic test_wide();
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      checks++;
      if (sclk_b !== m_clk(n_b, PB) || tick_b !== m_tick(n_b, PB) ||
          srn_b !== m_rn(n_b, PB, HB)) begin
        errors++;
        $display("FAIL wide edge %0d: clk=%b tick=%b rn=%b want %b %b %b",
                 n_b, sclk_b, tick_b, srn_b,
                 m_clk(n_b, PB), m_tick(n_b, PB), m_rn(n_b, PB, HB));
      end
      if (n_b == 1 || n_b == 2) begin
        checks++;
        if (srn_b !== logic'(n_b == 2)) begin
          errors++;
          $display("FAIL wide_release edge %0d: rn=%b", n_b, srn_b);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ra, rb;
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 39) != 0);
      rb = ($urandom_range(0, 9) != 0);
      step(ra, rb);
      checks++;
      if (sclk_a !== m_clk(n_a, PA) || tick_a !== m_tick(n_a, PA) ||
          srn_a !== m_rn(n_a, PA, HA)) begin
        errors++;
        $display("FAIL random_a n=%0d: clk=%b tick=%b rn=%b want %b %b %b",
                 n_a, sclk_a, tick_a, srn_a,
                 m_clk(n_a, PA), m_tick(n_a, PA), m_rn(n_a, PA, HA));
      end
      checks++;
      if (sclk_b !== m_clk(n_b, PB) || tick_b !== m_tick(n_b, PB) ||
          srn_b !== m_rn(n_b, PB, HB)) begin
        errors++;
        $display("FAIL random_b n=%0d: clk=%b tick=%b rn=%b want %b %b %b",
                 n_b, sclk_b, tick_b, srn_b,
                 m_clk(n_b, PB), m_tick(n_b, PB), m_rn(n_b, PB, HB));
      end
    end
  endtask

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;
    test_reset();
    test_divider();
    test_tick();
    test_release();
    test_mid_stretch();
    test_after_release();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
